// File: rtl/intra_chroma_pkg.sv
`default_nettype none
// ============================================================================
// Package : intra_chroma_pkg
// Purpose : Shared definitions for the 8x8 chroma intra mode-decision path:
//           mode codes, the controller state type and the block sample count.
// Revision: 1.0 - initial release
// ============================================================================
package intra_chroma_pkg;

  // Chroma intra mode codes as consumed by the transform stage
  localparam logic [1:0] CMODE_DC = 2'd0;
  localparam logic [1:0] CMODE_H  = 2'd1;
  localparam logic [1:0] CMODE_V  = 2'd2;

  // Residual samples in one 8x8 chroma block
  localparam int unsigned CHROMA_SAMPLES = 64;

  // Mode-decision controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ACC  = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } cstate_e;

endpackage : intra_chroma_pkg
`default_nettype wire

// File: rtl/sad_row_acc.sv
`default_nettype none
// ============================================================================
// Module  : sad_row_acc
// Purpose : Sums |r| over SPC two's-complement residual bytes and adds the
//           result into a saturating SAD accumulator.
// Ports   : clk      - clock, rising edge
//           reset    - asynchronous active-low reset
//           clear_i  - zero the accumulator (wins over en_i)
//           en_i     - add this cycle's row sum
//           samp_i   - SPC residual bytes
//           acc_o    - accumulated SAD, saturates at 2^ACC_W-1
// Revision: 1.0 - initial release
// ============================================================================
module sad_row_acc
  import intra_chroma_pkg::*;
#(
  parameter int ACC_W = 14,
  parameter int SPC   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [SPC-1:0][7:0]  samp_i,
  output logic [ACC_W-1:0]     acc_o
);

  // Row sum needs 8 + log2(SPC) bits; the add is done one bit wider than
  // the larger of that and the accumulator so saturation can be detected.
  localparam int SUM_W = 8 + $clog2(SPC) + 1;
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [SPC-1:0][7:0] mag;
  logic [EXT_W-1:0]    row_sum;
  logic [EXT_W-1:0]    total;
  logic [ACC_W-1:0]    acc_d, acc_q;

  // 8-bit magnitude: 0x80 negates to itself, which reads as 128 unsigned
  always_comb begin
    mag     = '0;
    row_sum = '0;
    for (int k = 0; k < SPC; k++) begin
      mag[k]  = samp_i[k][7] ? (8'd0 - samp_i[k]) : samp_i[k];
      row_sum = row_sum + EXT_W'(mag[k]);
    end
  end

  assign total = EXT_W'(acc_q) + row_sum;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = (total > EXT_W'(ACC_MAX)) ? ACC_MAX : total[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule : sad_row_acc
`default_nettype wire

// File: rtl/chroma8x8_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : chroma8x8_mode_ctrl
// Purpose : Sequencer and mode decision for the 8x8 chroma intra residual
//           stage. Pulses res_en, accumulates V/H/DC SADs SPC samples per
//           cycle, then picks the cheapest available mode (ties -> lower code).
// Ports   : clk, reset (async active-low)
//           start, top_avail, left_avail   - request + neighbour availability
//           res_en                         - residual stage enable pulse
//           vres, hres, dcres              - 64 residual bytes, raster order
//           busy, done                     - status / result-valid pulse
//           best_mode, best_sad            - decision (0=DC, 1=H, 2=V)
//           sad_dc, sad_h, sad_v           - all three SADs, only when
//                                            CHROMA8X8_SAD_OUT_EN is defined
// Config  : CHROMA8X8_SAD_OUT_EN
// Revision: 1.0 - initial release
// ============================================================================
module chroma8x8_mode_ctrl
  import intra_chroma_pkg::*;
#(
  parameter int ACC_W = 14,
  parameter int SPC   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               top_avail,
  input  logic               left_avail,
  output logic               res_en,
  input  logic [63:0][7:0]   vres,
  input  logic [63:0][7:0]   hres,
  input  logic [63:0][7:0]   dcres,
  output logic               busy,
  output logic               done,
  output logic [1:0]         best_mode,
  output logic [ACC_W-1:0]   best_sad
`ifdef CHROMA8X8_SAD_OUT_EN
  ,
  output logic [ACC_W-1:0]   sad_dc,
  output logic [ACC_W-1:0]   sad_h,
  output logic [ACC_W-1:0]   sad_v
`endif
);

  localparam logic [5:0] IDX_STEP = 6'(SPC);
  localparam logic [5:0] IDX_LAST = 6'(CHROMA_SAMPLES - SPC);

  cstate_e           state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic              top_q, top_d;
  logic              left_q, left_d;
  logic [1:0]        best_mode_q, best_mode_d;
  logic [ACC_W-1:0]  best_sad_q, best_sad_d;

  logic              acc_clear, acc_en;
  logic [ACC_W-1:0]  acc_v, acc_h, acc_dc;
  logic [1:0]        cand_mode;
  logic [ACC_W-1:0]  cand_sad;

  logic [SPC-1:0][7:0] v_slice, h_slice, dc_slice;

  // Current window of SPC samples starting at idx_q
  always_comb begin
    v_slice  = '0;
    h_slice  = '0;
    dc_slice = '0;
    for (int k = 0; k < SPC; k++) begin
      v_slice[k]  = vres[idx_q + 6'(k)];
      h_slice[k]  = hres[idx_q + 6'(k)];
      dc_slice[k] = dcres[idx_q + 6'(k)];
    end
  end

  sad_row_acc #(.ACC_W(ACC_W), .SPC(SPC)) u_acc_v (
    .clk(clk), .reset(reset), .clear_i(acc_clear), .en_i(acc_en),
    .samp_i(v_slice), .acc_o(acc_v)
  );

  sad_row_acc #(.ACC_W(ACC_W), .SPC(SPC)) u_acc_h (
    .clk(clk), .reset(reset), .clear_i(acc_clear), .en_i(acc_en),
    .samp_i(h_slice), .acc_o(acc_h)
  );

  sad_row_acc #(.ACC_W(ACC_W), .SPC(SPC)) u_acc_dc (
    .clk(clk), .reset(reset), .clear_i(acc_clear), .en_i(acc_en),
    .samp_i(dc_slice), .acc_o(acc_dc)
  );

  // DC is the baseline; H then V replace it only on a strictly lower SAD
  always_comb begin
    cand_mode = CMODE_DC;
    cand_sad  = acc_dc;
    if (left_q && (acc_h < cand_sad)) begin
      cand_mode = CMODE_H;
      cand_sad  = acc_h;
    end
    if (top_q && (acc_v < cand_sad)) begin
      cand_mode = CMODE_V;
      cand_sad  = acc_v;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    top_d       = top_q;
    left_d      = left_q;
    best_mode_d = best_mode_q;
    best_sad_d  = best_sad_q;
    acc_clear   = 1'b0;
    acc_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          top_d     = top_avail;
          left_d    = left_avail;
          acc_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_ACC;
        idx_d   = '0;
      end
      ST_ACC: begin
        acc_en = 1'b1;
        idx_d  = idx_q + IDX_STEP;
        if (idx_q == IDX_LAST) begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        best_mode_d = cand_mode;
        best_sad_d  = cand_sad;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      top_q       <= 1'b0;
      left_q      <= 1'b0;
      best_mode_q <= CMODE_DC;
      best_sad_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      top_q       <= top_d;
      left_q      <= left_d;
      best_mode_q <= best_mode_d;
      best_sad_q  <= best_sad_d;
    end
  end

`ifdef CHROMA8X8_SAD_OUT_EN
  logic [ACC_W-1:0] sad_dc_q, sad_h_q, sad_v_q;

  // Captured together with best_sad; unavailable modes are still reported
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sad_dc_q <= '0;
      sad_h_q  <= '0;
      sad_v_q  <= '0;
    end else if (state_q == ST_CMP) begin
      sad_dc_q <= acc_dc;
      sad_h_q  <= acc_h;
      sad_v_q  <= acc_v;
    end
  end

  assign sad_dc = sad_dc_q;
  assign sad_h  = sad_h_q;
  assign sad_v  = sad_v_q;
`endif

  // Decoded straight from the state register so reset clears them at once
  assign res_en    = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_ACC) || (state_q == ST_CMP);
  assign done      = (state_q == ST_DONE);
  assign best_mode = best_mode_q;
  assign best_sad  = best_sad_q;

endmodule : chroma8x8_mode_ctrl
`default_nettype wire

// File: doc/chroma8x8_mode_ctrl.md
# chroma8x8_mode_ctrl

Sequencer and mode-decision controller for the 8x8 chroma intra residual stage. On `start`, it pulses the residual stage's `enable` for one cycle. It then accumulates the sum of absolute residuals (SAD) for the vertical, horizontal and DC candidates, a fixed number of samples per cycle. When accumulation finishes it reports the cheapest available mode. It sits between the macroblock scheduler (start/done handshake) and the downstream transform stage, which consumes `best_mode`.

## Interface
- `ACC_W`, default 14: SAD accumulator width. Values of 14 or more never saturate.
- `SPC`, default 8: residual samples summed per cycle. Legal values are 4, 8 and 16.
- `clk` in 1: clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: request a decision. Sampled only in IDLE.
- `top_avail` in 1: top neighbour available, so V is a candidate. Sampled with `start`.
- `left_avail` in 1: left neighbour available, so H is a candidate. Sampled with `start`.
- `res_en` out 1: drives the residual stage `enable`.
- `vres`, `hres`, `dcres` in [7:0] x [63:0]: residual arrays from the residual stage, raster order.
- `busy` out 1: high from LOAD through CMP.
- `done` out 1: one-cycle pulse when the result is valid.
- `best_mode` out 2: 0 = DC, 1 = H, 2 = V. 3 is never produced.
- `best_sad` out ACC_W: SAD of the chosen mode.

## Operation
- FSM states are IDLE, LOAD, ACC, CMP and DONE.
- IDLE goes to LOAD on `start`. LOAD goes to ACC. ACC goes to CMP after 64/SPC cycles. CMP goes to DONE. DONE goes to IDLE.
- In LOAD, `res_en` = 1 for exactly one cycle. Residuals are valid from the first ACC cycle onward.
- In ACC, the sample index counter steps 0, SPC, 2·SPC, … up to 64−SPC. Each cycle adds |r| for samples [idx .. idx+SPC−1] into three accumulators.
- Each residual byte is treated as two's complement: |0x80| = 128 and |0xFF| = 1. The absolute value is 8 bits wide with no overflow.
- Accumulators clear on entry to LOAD. Each accumulator saturates at 2^ACC_W − 1.
- In CMP, DC is always a candidate. Candidates are visited in the order DC, H, V, and a later candidate replaces the current best only if its SAD is strictly less. Ties therefore favour the lower mode number.
- Unavailable modes are skipped. The sampled availability flags are held until DONE.
- `best_mode` and `best_sad` are registered at the end of CMP. They hold until the next CMP.
- `start` while busy is ignored; it is neither queued nor able to corrupt the run.
- `start` held high continuously re-triggers from IDLE, giving one decision every 4 + 64/SPC cycles.
- Reset values: state = IDLE; `res_en`, `busy`, `done` = 0; `best_mode` = 0; `best_sad` = 0; accumulators and counter = 0.
- Reset asserted mid-run aborts immediately with no `done`. `res_en` drops asynchronously.

## Timing
- Cycles are numbered from the `start` cycle as cycle 0 (IDLE).
- LOAD is cycle 1. ACC runs over cycles 2 .. 1+64/SPC. CMP is cycle 2+64/SPC. `done` is high in cycle 3+64/SPC.
- Default SPC = 8: `res_en` in cycle 1, ACC in cycles 2–9, CMP in cycle 10, `done` in cycle 11.
- `busy` is high in cycles 1 .. 2+64/SPC and low during DONE.
- A new `start` is accepted in the cycle after DONE, at the earliest.
- Residual inputs must be stable from cycle 2 until the last ACC cycle.

## Configuration
- `CHROMA8X8_SAD_OUT_EN` defined: adds outputs `sad_dc`, `sad_h` and `sad_v` (ACC_W each). They are registered with `best_sad`, reset to 0, and report all three SADs, including those of unavailable modes.
- `CHROMA8X8_SAD_OUT_EN` undefined: those ports do not exist and only `best_sad` is exported.

## Structure
- Shared package `intra_chroma_pkg` holds:
  - constants `CMODE_DC` = 0, `CMODE_H` = 1, `CMODE_V` = 2;
  - the FSM state typedef;
  - the sample count, 64.
- Sub-module `sad_row_acc`, instantiated three times. It performs abs-sum over SPC bytes plus a saturating accumulate, with inputs clear and en.
- The FSM, the index counter and the compare logic live in the top module.

## Test plan
- **Basic decision.** SPC = 8, both flags available, `vres` = 0, `hres` = 1, `dcres` = 2 everywhere → `done` at cycle 11, `best_mode` = 2, `best_sad` = 0, one `res_en` pulse at cycle 1.
- **Tie-break.** All residuals = 5 with both available → `best_mode` = 0, `best_sad` = 320.
- **Availability masking.** `top_avail` = 0, `vres` = 0, `hres` = 0x03, `dcres` = 0xFE everywhere → V skipped; H SAD = 192 and DC SAD = 128, so `best_mode` = 0, `best_sad` = 128.
- **Absolute-value edge and saturation.**
  - ACC_W = 14, `dcres` = 0x80 everywhere, H/V unavailable → `best_sad` = 8192.
  - ACC_W = 12 with the same stimulus → `best_sad` = 4095.
- **Handshake robustness.** `start` pulsed again in cycles 3 and 10 → ignored, one `done` only. Continuous `start` → `done` every 12 cycles.
- **Reset mid-run.** Assert `reset` in cycle 5 → `res_en`, `busy` and outputs go to 0 immediately with no `done`. A `start` after release completes normally in 11 cycles.
